// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode/IEU.
//  Owns the fetch PC, issues one word read at a time to instruction memory
//  (req/gnt/rvalid), buffers returned words with their PCs in a small FIFO
//  and presents the FIFO head downstream.
// Ports:
//  i_clk, i_rst         clock (rising edge), async active-high reset
//  pc_update_control    redirect request; pc_update_val is the target
//  stall_pc             downstream busy: hold head
//  ignore_curr_inst     squash: pop head without executing it
//  imem_req/addr/gnt    request channel (one outstanding at most)
//  imem_rvalid/rdata    in-order read return
//  pc/instr/instr_valid FIFO head (0 / NOP_INSTR / 0 when empty)
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        pc_update_control,
  input  logic [31:0] pc_update_val,
  input  logic        stall_pc,
  input  logic        ignore_curr_inst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_ent_t;

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;      // address of the request currently in flight
  logic          outstanding;
  logic          drop_pending;
  fetch_ent_t    fifo_q [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic          head_vld, grant, push, pop, outstanding_after;
  logic [CW:0]   occ;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^pc_update_val[1:0];

  assign head_vld          = (count != '0);
  assign grant             = imem_req & imem_gnt;
  assign push              = imem_rvalid & ~drop_pending & ~pc_update_control;
  assign pop               = head_vld & ~pc_update_control & (ignore_curr_inst | ~stall_pc);
  assign outstanding_after = outstanding & ~imem_rvalid;

  // Slots committed after this edge: current entries, this cycle's push and
  // pop, plus a request still in flight. A new request is only issued when its
  // return is guaranteed a slot, so the FIFO cannot overflow even when the
  // consumer stalls right as a word lands.
  assign occ = {1'b0, count} + {{CW{1'b0}}, push} + {{CW{1'b0}}, outstanding_after}
             - {{CW{1'b0}}, pop};

  assign imem_req  = ~i_rst & ~pc_update_control & (~outstanding | imem_rvalid)
                   & (occ < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_pc     <= RESET_PC;
      req_pc       <= '0;
      outstanding  <= 1'b0;
      drop_pending <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
    end else begin
      if (imem_rvalid) outstanding <= 1'b0;
      if (grant) begin
        outstanding <= 1'b1;
        req_pc      <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (pc_update_control) begin
        fetch_pc     <= {pc_update_val[31:2], 2'b00};
        rd_ptr       <= '0;
        wr_ptr       <= '0;
        count        <= '0;
        // in-flight word belongs to the old path; a coincident return is
        // simply not pushed
        drop_pending <= outstanding & ~imem_rvalid;
      end else begin
        if (imem_rvalid) drop_pending <= 1'b0;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push & ~pop)      count <= count + 1'b1;
        else if (pop & ~push) count <= count - 1'b1;
      end
    end
  end

  // Entry storage needs no reset: outputs are masked by head_vld.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    always_ff @(posedge i_clk) begin
      if (push && wr_ptr == AW'(i)) fifo_q[i] <= '{pc: req_pc, instr: imem_rdata};
    end
  end

  assign pc          = head_vld ? fifo_q[rd_ptr].pc    : 32'h0;
  assign instr       = head_vld ? fifo_q[rd_ptr].instr : NOP_INSTR;
  assign instr_valid = head_vld & ~ignore_curr_inst;

  a_rvalid_outstanding: assert property (@(posedge i_clk) disable iff (i_rst)
    imem_rvalid |-> outstanding);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit with a queue-based model of
//  the instruction stream and a single-outstanding memory model.
module tb_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic        pc_update_control = 1'b0;
  logic [31:0] pc_update_val = '0;
  logic        stall_pc = 1'b0, ignore_curr_inst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc, instr;
  logic        instr_valid;

  always #5 i_clk = ~i_clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .pc_update_control(pc_update_control), .pc_update_val(pc_update_val),
    .stall_pc(stall_pc), .ignore_curr_inst(ignore_curr_inst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc), .instr(instr), .instr_valid(instr_valid)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        q[$];      // instructions the consumer should see, in order
  logic [31:0] m_pc;      // next address expected on a grant
  bit          m_pend, m_drop;
  logic [31:0] m_addr;
  int          m_dly;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc = RESET_PC; m_pend = 0; m_drop = 0; m_addr = '0; m_dly = 0;
  endtask

  // One clock cycle; entered at posedge+1, leaves at the next posedge+1.
  task automatic cyc(input bit st, input bit ig, input bit rd, input logic [31:0] rv,
                     input bit g, input int dly, output logic o_vld, output logic [31:0] o_pc);
    bit rval, grant, popm;
    ent_t e;
    stall_pc = st; ignore_curr_inst = ig; pc_update_control = rd; pc_update_val = rv;
    imem_gnt = g;
    rval = m_pend && (m_dly == 0);
    imem_rvalid = rval;
    imem_rdata  = rval ? mem_word(m_addr) : $urandom;
    #3;
    o_vld = instr_valid; o_pc = pc;
    if (q.size() > 0) begin
      chk("head_pc", pc, q[0].pc);
      chk("head_instr", instr, q[0].ins);
      chk("head_vld", instr_valid, {31'b0, !ig});
    end else begin
      chk("empty_pc", pc, 32'h0);
      chk("empty_instr", instr, NOP);
      chk("empty_vld", instr_valid, 32'h0);
    end
    popm  = (q.size() > 0) && (ig || !st);
    grant = imem_req && g;
    if (rd) chk("req_redir", imem_req, 32'h0);
    if (m_pend && !rval) chk("req_outst", imem_req, 32'h0);
    if (!rd && q.size() >= DEPTH && !popm) chk("req_full", imem_req, 32'h0);
    if (grant) chk("grant_addr", imem_addr, m_pc);
    if (rd) begin
      q.delete();
      m_pc   = {rv[31:2], 2'b00};
      m_drop = m_pend && !rval;
    end else begin
      if (popm) void'(q.pop_front());
      if (rval) begin
        if (m_drop) m_drop = 0;
        else begin e.pc = m_addr; e.ins = mem_word(m_addr); q.push_back(e); end
      end
      if (grant) m_pc = m_pc + 32'd4;
    end
    chk("no_overflow", {31'b0, q.size() <= DEPTH}, 32'h1);
    if (rval) m_pend = 0;
    if (grant) begin m_pend = 1; m_addr = imem_addr; m_dly = dly; end
    else if (m_pend && m_dly > 0) m_dly--;
    @(posedge i_clk); #1;
  endtask

  logic        v;
  logic [31:0] p, p0;
  bit          found;

  initial begin
    model_reset();
    #2;
    chk("rst_req", imem_req, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_vld", instr_valid, 32'h0);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;

    // back-to-back fetch with 1-cycle memory
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0, 1, 0, v, p);
      if (i >= 2) begin
        chk("thru_vld", v, 32'h1);
        chk("thru_pc", p, 32'(4 * (i - 2)));
      end
    end

    // stall with FIFO filling: head must hold
    cyc(1, 0, 0, 0, 1, 0, v, p0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 1, 0, v, p);
      chk("stall_hold", p, p0);
    end
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1, 0, v, p);

    // redirect with nothing outstanding, latency, then squash pc=8
    while (m_pend) cyc(0, 0, 0, 0, 0, 0, v, p);
    cyc(0, 0, 1, 32'h0, 1, 0, v, p);
    cyc(0, 0, 0, 0, 1, 0, v, p);
    cyc(0, 0, 0, 0, 1, 0, v, p);
    cyc(0, 0, 0, 0, 1, 0, v, p);
    chk("redir_lat_vld", v, 32'h1);
    chk("redir_lat_pc", p, 32'h0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (q.size() > 0 && q[0].pc == 32'h8) begin
        found = 1;
        cyc(0, 1, 0, 0, 1, 0, v, p);
        chk("ign_vld", v, 32'h0);
        chk("ign_pc", p, 32'h8);
        cyc(0, 0, 0, 0, 1, 0, v, p);
        chk("ign_next", p, 32'hC);
      end else cyc(0, 0, 0, 0, 1, 0, v, p);
    end
    chk("ign_found", {31'b0, found}, 32'h1);

    // redirect to an unaligned target while a request is in flight
    found = 0;
    for (int i = 0; i < 10 && !m_pend; i++) cyc(0, 0, 0, 0, 1, 2, v, p);
    chk("outst_setup", {31'b0, m_pend}, 32'h1);
    cyc(0, 0, 1, 32'h0000_0102, 1, 0, v, p);
    for (int i = 0; i < 12 && !found; i++) begin
      cyc(0, 0, 0, 0, 1, 0, v, p);
      if (v) begin found = 1; chk("stale_drop_pc", p, 32'h0000_0100); end
    end
    chk("stale_found", {31'b0, found}, 32'h1);

    // address wrap
    while (m_pend) cyc(0, 0, 0, 0, 0, 0, v, p);
    cyc(0, 0, 1, 32'hFFFF_FFFC, 1, 0, v, p);
    cyc(0, 0, 0, 0, 1, 0, v, p);
    cyc(0, 0, 0, 0, 1, 0, v, p);
    cyc(0, 0, 0, 0, 1, 0, v, p);
    chk("wrap_pc0", p, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 1, 0, v, p);
    chk("wrap_pc1", p, 32'h0);

    // asynchronous reset mid-request
    for (int i = 0; i < 10 && !m_pend; i++) cyc(0, 0, 0, 0, 1, 2, v, p);
    imem_gnt = 0; imem_rvalid = 0; pc_update_control = 0; stall_pc = 0; ignore_curr_inst = 0;
    #2 i_rst = 1'b1;
    #1;
    chk("arst_req", imem_req, 32'h0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_instr", instr, NOP);
    chk("arst_vld", instr_valid, 32'h0);
    model_reset();
    @(posedge i_clk); #1 i_rst = 1'b0;
    cyc(0, 0, 0, 0, 1, 0, v, p);
    cyc(0, 0, 0, 0, 1, 0, v, p);
    cyc(0, 0, 0, 0, 1, 0, v, p);
    chk("arst_restart", p, RESET_PC);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
          tgt, $urandom_range(0, 9) < 7, $urandom_range(0, 2), v, p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
